key_time_setter: RTL and testbench



---
 rtl/key_time_setter_pkg.sv | 34 +++
 rtl/key_time_setter_bcd_step.sv | 32 +++
 rtl/key_time_setter.sv | 181 ++++++++++++++++++
 tb/tb_key_time_setter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_time_setter_pkg.sv
// Shared types and constants for the key-driven time editor.
// Holds the FSM state encoding, field codes, key indices and BCD limits.
package time_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_H,
        ST_EDIT_M,
        ST_EDIT_S,
        ST_COMMIT
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_H    = 2'd1;
    localparam logic [1:0] FIELD_M    = 2'd2;
    localparam logic [1:0] FIELD_S    = 2'd3;

    localparam int unsigned KEY_NEXT   = 0;
    localparam int unsigned KEY_INC    = 1;
    localparam int unsigned KEY_DEC    = 2;
    localparam int unsigned KEY_CANCEL = 3;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // Valid BCD is monotone in its binary value, so a plain compare against max works.
    function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max);
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > max)) begin
            return 8'h00;
        end
        return v;
    endfunction

endpackage

// File: rtl/key_time_setter_bcd_step.sv
// Single-step wrapping BCD increment/decrement between 00 and max.
// Inputs outside the legal range wrap to the nearest end so results stay valid BCD.
module bcd_step (
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] result
);

    always_comb begin
        result = value;
        if (inc) begin
            if (value >= max) begin
                result = 8'h00;
            end else if (value[3:0] >= 4'd9) begin
                result = {value[7:4] + 4'd1, 4'd0};
            end else begin
                result = {value[7:4], value[3:0] + 4'd1};
            end
        end else if (dec) begin
            if ((value == 8'h00) || (value > max)) begin
                result = max;
            end else if (value[3:0] == 4'd0) begin
                result = {value[7:4] - 4'd1, 4'd9};
            end else begin
                result = {value[7:4], value[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/key_time_setter.sv
// Key-driven hour/minute/second edit session producing a BCD set time and an
// acknowledged write request towards the DS1302 writer.
module key_time_setter
    import time_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 1000,
    parameter int unsigned BLINK_TICKS   = 50
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic [3:0] down,
    input  logic [7:0] rtc_hour,
    input  logic [7:0] rtc_min,
    input  logic [7:0] rtc_sec,
    input  logic       write_ack,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic       write_req,
    output logic [1:0] edit_field,
    output logic       blink
);

    localparam int unsigned TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam int unsigned BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

    state_e          state_q, state_d;
    logic [7:0]      hour_q, hour_d;
    logic [7:0]      min_q, min_d;
    logic [7:0]      sec_q, sec_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            blink_q, blink_d;
    logic            ack_meta_q, ack_sync_q;

    logic            key_cancel, key_next, key_inc, key_dec, any_key;
    logic            in_edit;
    logic [7:0]      field_val, field_max, field_step;

    // Only the highest-priority key acts: cancel > next > inc > dec.
    assign key_cancel = down[KEY_CANCEL];
    assign key_next   = down[KEY_NEXT] & ~down[KEY_CANCEL];
    assign key_inc    = down[KEY_INC] & ~down[KEY_CANCEL] & ~down[KEY_NEXT];
    assign key_dec    = down[KEY_DEC] & ~down[KEY_CANCEL] & ~down[KEY_NEXT] & ~down[KEY_INC];
    assign any_key    = |down;
    assign in_edit    = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) || (state_q == ST_EDIT_S);

    always_comb begin
        field_val = hour_q;
        field_max = HOUR_MAX;
        case (state_q)
            ST_EDIT_M: begin
                field_val = min_q;
                field_max = MINSEC_MAX;
            end
            ST_EDIT_S: begin
                field_val = sec_q;
                field_max = MINSEC_MAX;
            end
            default: ;
        endcase
    end

    bcd_step u_bcd_step (
        .value  (field_val),
        .max    (field_max),
        .inc    (key_inc & in_edit),
        .dec    (key_dec & in_edit),
        .result (field_step)
    );

    always_comb begin
        state_d  = state_q;
        hour_d   = hour_q;
        min_d    = min_q;
        sec_d    = sec_q;
        to_cnt_d = '0;
        bl_cnt_d = '0;
        blink_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_next) begin
                    hour_d  = bcd_sanitize(rtc_hour, HOUR_MAX);
                    min_d   = bcd_sanitize(rtc_min, MINSEC_MAX);
                    sec_d   = bcd_sanitize(rtc_sec, MINSEC_MAX);
                    state_d = ST_EDIT_H;
                    blink_d = 1'b1;
                end
            end

            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (any_key) begin
                    // Any press restarts timeout and blink phase, showing the field at once.
                    blink_d = 1'b1;
                    if (key_cancel) begin
                        state_d = ST_IDLE;
                        blink_d = 1'b0;
                    end else if (key_next) begin
                        case (state_q)
                            ST_EDIT_H: state_d = ST_EDIT_M;
                            ST_EDIT_M: state_d = ST_EDIT_S;
                            default: begin
                                state_d = ST_COMMIT;
                                blink_d = 1'b0;
                            end
                        endcase
                    end else begin
                        case (state_q)
                            ST_EDIT_H: hour_d = field_step;
                            ST_EDIT_M: min_d  = field_step;
                            default:   sec_d  = field_step;
                        endcase
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (bl_cnt_q == BL_LAST) begin
                        bl_cnt_d = '0;
                        blink_d  = ~blink_q;
                    end else begin
                        bl_cnt_d = bl_cnt_q + 1'b1;
                        blink_d  = blink_q;
                    end
                end
            end

            ST_COMMIT: begin
                if (ack_sync_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hour_q     <= 8'h00;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            to_cnt_q   <= '0;
            bl_cnt_q   <= '0;
            blink_q    <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            to_cnt_q   <= to_cnt_d;
            bl_cnt_q   <= bl_cnt_d;
            blink_q    <= blink_d;
            ack_meta_q <= write_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    always_comb begin
        edit_field = FIELD_NONE;
        case (state_q)
            ST_EDIT_H: edit_field = FIELD_H;
            ST_EDIT_M: edit_field = FIELD_M;
            ST_EDIT_S: edit_field = FIELD_S;
            default:   edit_field = FIELD_NONE;
        endcase
    end

    assign write_req = (state_q == ST_COMMIT);
    assign blink     = blink_q;
    assign set_hour  = hour_q;
    assign set_min   = min_q;
    assign set_sec   = sec_q;

endmodule

// File: tb/tb_key_time_setter.sv
// Bench for key_time_setter: directed scenarios plus random key/ack traffic,
// checked against a decimal-arithmetic reference model of the edit session.
module tb_key_time_setter;

    localparam int unsigned TIMEOUT_TICKS = 1000;
    localparam int unsigned BLINK_TICKS   = 50;

    logic       clk_100 = 1'b0;
    logic       rst_n;
    logic [3:0] down;
    logic [7:0] rtc_hour, rtc_min, rtc_sec;
    logic       write_ack;
    logic [7:0] set_hour, set_min, set_sec;
    logic       write_req;
    logic [1:0] edit_field;
    logic       blink;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1..3 editing hour/min/sec, 4 committing.
    int m_mode, m_h, m_m, m_s, m_since;
    bit ackq[$];

    key_time_setter #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .BLINK_TICKS   (BLINK_TICKS)
    ) dut (
        .clk_100    (clk_100),
        .rst_n      (rst_n),
        .down       (down),
        .rtc_hour   (rtc_hour),
        .rtc_min    (rtc_min),
        .rtc_sec    (rtc_sec),
        .write_ack  (write_ack),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .write_req  (write_req),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int load_val(input logic [7:0] r, input int max);
        int hi = int'(r[7:4]);
        int lo = int'(r[3:0]);
        if (hi > 9 || lo > 9 || (hi * 10 + lo) > max) return 0;
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_h     = 0;
        m_m     = 0;
        m_s     = 0;
        m_since = 0;
        ackq.delete();
    endtask

    task automatic adjust_field(input int delta);
        case (m_mode)
            1: m_h = (m_h + delta + 24) % 24;
            2: m_m = (m_m + delta + 60) % 60;
            default: m_s = (m_s + delta + 60) % 60;
        endcase
    endtask

    task automatic model_step();
        bit acked = 1'b0;
        ackq.push_back(write_ack);
        if (ackq.size() == 3) begin
            acked = ackq[0];
            void'(ackq.pop_front());
        end
        case (m_mode)
            0: begin
                if (!down[3] && down[0]) begin
                    m_h = load_val(rtc_hour, 23);
                    m_m = load_val(rtc_min, 59);
                    m_s = load_val(rtc_sec, 59);
                    m_mode = 1;
                    m_since = 0;
                end
            end
            1, 2, 3: begin
                if (down != 4'b0000) begin
                    m_since = 0;
                    if (down[3])      m_mode = 0;
                    else if (down[0]) m_mode = m_mode + 1;
                    else if (down[1]) adjust_field(1);
                    else              adjust_field(-1);
                end else begin
                    m_since++;
                    if (m_since >= TIMEOUT_TICKS) m_mode = 0;
                end
            end
            default: begin
                if (acked) m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        bit exp_blink = (m_mode >= 1 && m_mode <= 3) && (((m_since / BLINK_TICKS) % 2) == 0);
        check_eq("set_hour", set_hour, to_bcd(m_h));
        check_eq("set_min", set_min, to_bcd(m_m));
        check_eq("set_sec", set_sec, to_bcd(m_s));
        check_eq("write_req", {7'd0, write_req}, {7'd0, m_mode == 4});
        check_eq("edit_field", {6'd0, edit_field}, (m_mode <= 3) ? 8'(m_mode) : 8'd0);
        check_eq("blink", {7'd0, blink}, {7'd0, exp_blink});
    endtask

    task automatic tick(input logic [3:0] d, input logic a);
        down      = d;
        write_ack = a;
        @(posedge clk_100);
        model_step();
        #1;
        compare_all();
        down = 4'b0000;
    endtask

    task automatic set_rtc(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        rtc_hour = h;
        rtc_min  = m;
        rtc_sec  = s;
    endtask

    initial begin
        logic ack_r;
        rst_n     = 1'b0;
        down      = 4'b0000;
        write_ack = 1'b0;
        set_rtc(8'h12, 8'h34, 8'h56);
        model_reset();
        repeat (2) @(posedge clk_100);
        @(negedge clk_100);
        rst_n = 1'b1;
        check_eq("rst_hour", set_hour, 8'h00);
        check_eq("rst_req", {7'd0, write_req}, 8'h00);
        check_eq("rst_field", {6'd0, edit_field}, 8'h00);
        check_eq("rst_blink", {7'd0, blink}, 8'h00);

        // Entry loads the RTC time.
        tick(4'b0001, 1'b0);
        check_eq("entry_field", {6'd0, edit_field}, 8'd1);
        check_eq("entry_hour", set_hour, 8'h12);
        check_eq("entry_min", set_min, 8'h34);
        check_eq("entry_sec", set_sec, 8'h56);
        check_eq("entry_blink", {7'd0, blink}, 8'd1);

        // Wrap boundaries.
        tick(4'b1000, 1'b0);
        set_rtc(8'h23, 8'h00, 8'h09);
        tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b0);
        check_eq("hour_inc_wrap", set_hour, 8'h00);
        tick(4'b0100, 1'b0);
        check_eq("hour_dec_wrap", set_hour, 8'h23);
        tick(4'b0001, 1'b0);
        tick(4'b0100, 1'b0);
        check_eq("min_dec_wrap", set_min, 8'h59);
        tick(4'b1000, 1'b0);
        set_rtc(8'h23, 8'h09, 8'h00);
        tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b0);
        check_eq("min_carry", set_min, 8'h10);

        // Cancel outranks increment.
        tick(4'b1010, 1'b0);
        check_eq("cancel_field", {6'd0, edit_field}, 8'd0);
        check_eq("cancel_min", set_min, 8'h10);
        check_eq("cancel_req", {7'd0, write_req}, 8'd0);

        // Next outranks increment.
        set_rtc(8'h12, 8'h34, 8'h56);
        tick(4'b0001, 1'b0);
        tick(4'b0011, 1'b0);
        check_eq("prio_field", {6'd0, edit_field}, 8'd2);
        check_eq("prio_hour", set_hour, 8'h12);

        // Commit handshake.
        tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b0);
        check_eq("commit_req", {7'd0, write_req}, 8'd1);
        check_eq("commit_field", {6'd0, edit_field}, 8'd0);
        tick(4'b1111, 1'b0);
        tick(4'b0111, 1'b0);
        check_eq("commit_hold_sec", set_sec, 8'h56);
        tick(4'b0000, 1'b1);
        check_eq("ack_e1", {7'd0, write_req}, 8'd1);
        tick(4'b0000, 1'b1);
        check_eq("ack_e2", {7'd0, write_req}, 8'd1);
        tick(4'b0000, 1'b1);
        check_eq("ack_e3", {7'd0, write_req}, 8'd0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);

        // Out-of-range RTC values load as 00.
        set_rtc(8'h24, 8'h5A, 8'h60);
        tick(4'b0001, 1'b0);
        check_eq("bad_hour", set_hour, 8'h00);
        check_eq("bad_min", set_min, 8'h00);
        check_eq("bad_sec", set_sec, 8'h00);

        // Timeout with a restart at cycle 999.
        tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b0);
        repeat (998) tick(4'b0000, 1'b0);
        tick(4'b0010, 1'b0);
        repeat (999) tick(4'b0000, 1'b0);
        check_eq("timeout_999", {6'd0, edit_field}, 8'd3);
        tick(4'b0000, 1'b0);
        check_eq("timeout_1000", {6'd0, edit_field}, 8'd0);
        check_eq("timeout_req", {7'd0, write_req}, 8'd0);

        // Reset while committing, then a stale ack.
        set_rtc(8'h07, 8'h08, 8'h09);
        repeat (4) tick(4'b0001, 1'b0);
        tick(4'b0000, 1'b1);
        check_eq("pre_rst_req", {7'd0, write_req}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_req", {7'd0, write_req}, 8'd0);
        check_eq("mid_rst_hour", set_hour, 8'h00);
        check_eq("mid_rst_sec", set_sec, 8'h00);
        check_eq("mid_rst_field", {6'd0, edit_field}, 8'd0);
        repeat (2) @(posedge clk_100);
        @(negedge clk_100);
        rst_n = 1'b1;
        repeat (4) tick(4'b0000, 1'b1);
        check_eq("stale_ack_field", {6'd0, edit_field}, 8'd0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);

        // Random traffic.
        ack_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] d;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    set_rtc(to_bcd(int'($urandom_range(0, 23))), to_bcd(int'($urandom_range(0, 59))),
                            to_bcd(int'($urandom_range(0, 59))));
                else
                    set_rtc(8'($urandom), 8'($urandom), 8'($urandom));
            end
            if ($urandom_range(0, 9) == 0) ack_r = ~ack_r;
            d = ($urandom_range(0, 9) < 6) ? 4'b0000 : 4'($urandom_range(1, 15));
            tick(d, ack_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
